// File: rtl/uac_mic_iis_capture_pkg.sv
// uac_mic_iis_capture_pkg: shared constants and capture FSM state type for the UAC mic block
package uac_mic_iis_capture_pkg;
    localparam logic LRCK_LEFT = 1'b0;
    localparam int MAX_SAMPLE_BYTES = 4;
    typedef enum logic [1:0] {CAP_SYNC, CAP_LEFT, CAP_RIGHT} cap_state_t;
endpackage

// File: rtl/uac_sync_fifo.sv
// uac_sync_fifo: single-clock first-word-fall-through FIFO with occupancy output
module uac_sync_fifo #(
    parameter int W  = 48,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign wr = push && !full;
    assign rd = pop && level != '0;
    assign full = level[AW];
    assign dout = mem[rp];
    // Frame storage; a flushed cycle writes nothing
    always_ff @(posedge clk) begin
        if (wr && !flush) mem[wp] <= din;
    end
    // Pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            level <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/uac_mic_iis_capture.sv
// uac_mic_iis_capture: I2S slave capture into a frame FIFO, drained as one isochronous IN packet per SOF
module uac_mic_iis_capture
    import uac_mic_iis_capture_pkg::*;
#(
    parameter int SAMPLE_BYTES = 3,
    parameter int FIFO_AW      = 7,
    parameter int MAX_FRAMES   = 12,
    parameter int EP_NUM       = 1,
    parameter int IF_NUM       = 2
) (
    input  logic               i_clk60,
    input  logic               i_reset,
    input  logic               i_usb_busreset,
    input  logic               i_usb_sof,
    input  logic [3:0]         i_usb_endpt_sel,
    input  logic               i_usb_txact,
    input  logic               i_usb_txpop,
    input  logic               i_usb_txpktfin,
    output logic               o_usb_txval,
    output logic [7:0]         o_usb_txdat,
    output logic [11:0]        o_usb_txdat_len,
    output logic               o_usb_txcork,
    input  logic [7:0]         i_interface_sel,
    input  logic [7:0]         i_interface_alter,
    input  logic               i_interface_update,
    input  logic               i_mic_iis_bclk,
    input  logic               i_mic_iis_lrck,
    input  logic               i_mic_iis_data,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_fifo_level
);
    localparam int SB = SAMPLE_BYTES > MAX_SAMPLE_BYTES ? MAX_SAMPLE_BYTES : SAMPLE_BYTES;
    localparam int BW = 8 * SB;
    localparam int FW = 2 * BW;
    localparam int NB = 2 * SB;
    localparam int CW = $clog2(BW + 1);
    localparam int IW = $clog2(NB);
    localparam logic [FIFO_AW:0] MAXF = (FIFO_AW+1)'(MAX_FRAMES);
    logic [1:0] bclk_s, lrck_s, data_s;
    logic bclk_d, lrck_p, ch_q, rise, chg, lat_l, push, pop, full, last, tx_take;
    logic [BW-1:0] sh, lw, word;
    logic [CW-1:0] cnt;
    cap_state_t state, state_n;
    logic stream_en, hit, flush, ovf;
    logic [11:0] len, bl, arm_len;
    logic [IW-1:0] bi;
    logic [FW-1:0] head;
    logic [FIFO_AW:0] level, n_arm;
    assign hit = i_interface_update && i_interface_sel == 8'(IF_NUM);
    assign flush = i_usb_busreset || (hit && i_interface_alter == 8'd0);
    assign rise = bclk_s[1] && !bclk_d;
    assign chg = rise && lrck_p != ch_q;
    assign word = sh << (CW'(BW) - cnt);
    // Pin synchronizers, one-bit-delayed channel tracking and MSB-first word assembly
    always_ff @(posedge i_clk60 or posedge i_reset) begin
        if (i_reset) begin
            bclk_s <= '0;
            lrck_s <= '0;
            data_s <= '0;
            bclk_d <= 1'b0;
            lrck_p <= 1'b0;
            ch_q <= 1'b0;
            sh <= '0;
            cnt <= '0;
            lw <= '0;
        end else begin
            bclk_s <= {bclk_s[0], i_mic_iis_bclk};
            lrck_s <= {lrck_s[0], i_mic_iis_lrck};
            data_s <= {data_s[0], i_mic_iis_data};
            bclk_d <= bclk_s[1];
            if (rise) begin
                lrck_p <= lrck_s[1];
                ch_q <= lrck_p;
                if (chg) begin
                    sh <= BW'(data_s[1]);
                    cnt <= CW'(1);
                end else if (cnt != CW'(BW)) begin
                    sh <= {sh[BW-2:0], data_s[1]};
                    cnt <= cnt + CW'(1);
                end
            end
            if (lat_l) lw <= word;
        end
    end
    // Capture state register; a stream flush restarts alignment
    always_ff @(posedge i_clk60 or posedge i_reset) begin
        if (i_reset) state <= CAP_SYNC;
        else state <= flush ? CAP_SYNC : state_n;
    end
    // Capture next state: only a right-to-left change leaves SYNC
    always_comb begin
        state_n = !chg ? state :
                  state == CAP_SYNC ? (lrck_p == LRCK_LEFT ? CAP_LEFT : CAP_SYNC) :
                  state == CAP_LEFT ? CAP_RIGHT : CAP_LEFT;
    end
    // Capture outputs: latch left word, push frame when the right word closes
    always_comb begin
        lat_l = chg && state == CAP_LEFT;
        push = chg && state == CAP_RIGHT && stream_en && !flush;
    end
    uac_sync_fifo #(.W(FW), .AW(FIFO_AW)) u_fifo (
        .clk(i_clk60),
        .rst(i_reset),
        .flush(flush),
        .push(push),
        .din({word, lw}),
        .pop(pop),
        .dout(head),
        .full(full),
        .level(level)
    );
    assign n_arm = level > MAXF ? MAXF : level;
    assign arm_len = 12'(n_arm) * 12'(NB);
    assign last = bi == IW'(NB - 1);
    assign tx_take = o_usb_txval && i_usb_txpop;
    assign pop = tx_take && last && !flush;
    assign o_usb_txval = stream_en && i_usb_txact && i_usb_endpt_sel == 4'(EP_NUM) && bl != 12'd0;
    assign o_usb_txdat = o_usb_txval ? 8'(head >> {bi, 3'b000}) : 8'd0;
    assign o_usb_txdat_len = len;
    assign o_usb_txcork = !stream_en;
    assign o_overflow = ovf;
    assign o_fifo_level = level;
    // Stream enable, sticky overflow and per-packet byte tracking
    always_ff @(posedge i_clk60 or posedge i_reset) begin
        if (i_reset) begin
            stream_en <= 1'b0;
            ovf <= 1'b0;
            len <= '0;
            bl <= '0;
            bi <= '0;
        end else begin
            if (hit) stream_en <= i_interface_alter != 8'd0;
            if (i_usb_busreset) stream_en <= 1'b0;
            ovf <= !i_usb_busreset && (ovf || (push && full));
            if (flush) begin
                len <= '0;
                bl <= '0;
                bi <= '0;
            end else if (i_usb_sof && !i_usb_txact) begin
                len <= stream_en ? arm_len : 12'd0;
                bl <= stream_en ? arm_len : 12'd0;
                bi <= '0;
            end else begin
                if (tx_take) begin
                    bl <= bl - 12'd1;
                    bi <= last ? '0 : bi + IW'(1);
                end
                if (i_usb_txpktfin) bl <= '0;
            end
        end
    end
endmodule
